// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM states,
// opcodes, ALU operation codes and datapath select encodings.
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } statetype;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_controller_aludec.sv
// ALU operation decoder: maps the FSM's aluop plus instruction fields
// onto the 3-bit alucontrol code; always resolves to a defined value.
module aludec
  import riscv_pkg::*;
(
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [1:0] aluop,
  output logic [2:0] alucontrol
);

  // ALU operation select
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op5 separates R-type from I-ALU, so addi never subtracts
          3'b000:  alucontrol = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b100:  alucontrol = ALU_XOR;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V control unit: instruction-sequencing FSM, Moore output
// decode, immediate-format decode and the ALU operation decoder.
module mc_controller
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] immsrc,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  statetype   state_r, next_s;
  logic       pcupdate_s, branch_s, adrsrc_s, memwrite_s, irwrite_s;
  logic       regwrite_s, illegal_s;
  logic [1:0] resultsrc_s, alusrca_s, alusrcb_s, aluop_s;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_s = S_FETCH;
    case (state_r)
      S_FETCH: next_s = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: next_s = S_MEMADR;
          OP_RTYPE:     next_s = S_EXECUTER;
          OP_IALU:      next_s = S_EXECUTEI;
          OP_JAL:       next_s = S_JAL;
          OP_BEQ:       next_s = S_BEQ;
          default:      next_s = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW) begin
          next_s = S_MEMREAD;
        end else begin
          next_s = S_MEMWRITE;
        end
      end
      S_MEMREAD:  next_s = S_MEMWB;
      S_MEMWB:    next_s = S_FETCH;
      S_MEMWRITE: next_s = S_FETCH;
      S_EXECUTER: next_s = S_ALUWB;
      S_EXECUTEI: next_s = S_ALUWB;
      S_ALUWB:    next_s = S_FETCH;
      S_BEQ:      next_s = S_FETCH;
      S_JAL:      next_s = S_ALUWB;
      default:    next_s = S_FETCH;
    endcase
  end

  // Moore output decode
  always_comb begin
    pcupdate_s  = 1'b0;
    branch_s    = 1'b0;
    adrsrc_s    = 1'b0;
    memwrite_s  = 1'b0;
    irwrite_s   = 1'b0;
    regwrite_s  = 1'b0;
    illegal_s   = 1'b0;
    resultsrc_s = RES_ALUOUT;
    alusrca_s   = SRCA_PC;
    alusrcb_s   = SRCB_RS2;
    aluop_s     = ALUOP_ADD;
    case (state_r)
      S_FETCH: begin
        irwrite_s   = 1'b1;
        pcupdate_s  = 1'b1;
        alusrcb_s   = SRCB_FOUR;
        resultsrc_s = RES_ALURESULT;
      end
      S_DECODE: begin
        alusrca_s = SRCA_OLDPC;
        alusrcb_s = SRCB_IMM;
        case (op)
          OP_LW, OP_SW, OP_RTYPE, OP_IALU, OP_JAL, OP_BEQ: illegal_s = 1'b0;
          default:                                         illegal_s = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alusrca_s = SRCA_RS1;
        alusrcb_s = SRCB_IMM;
      end
      S_MEMREAD: adrsrc_s = 1'b1;
      S_MEMWB: begin
        resultsrc_s = RES_DATA;
        regwrite_s  = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc_s   = 1'b1;
        memwrite_s = 1'b1;
      end
      S_EXECUTER: begin
        alusrca_s = SRCA_RS1;
        aluop_s   = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        alusrca_s = SRCA_RS1;
        alusrcb_s = SRCB_IMM;
        aluop_s   = ALUOP_FUNCT;
      end
      S_ALUWB: regwrite_s = 1'b1;
      S_BEQ: begin
        alusrca_s = SRCA_RS1;
        aluop_s   = ALUOP_SUB;
        branch_s  = 1'b1;
      end
      S_JAL: begin
        alusrca_s  = SRCA_OLDPC;
        alusrcb_s  = SRCB_FOUR;
        pcupdate_s = 1'b1;
      end
      default: irwrite_s = 1'b0;
    endcase
  end

  // Immediate format follows the opcode in every state
  always_comb begin
    immsrc = IMM_I;
    case (op)
      OP_LW, OP_IALU: immsrc = IMM_I;
      OP_SW:          immsrc = IMM_S;
      OP_BEQ:         immsrc = IMM_B;
      OP_JAL:         immsrc = IMM_J;
      default:        immsrc = IMM_I;
    endcase
  end

  aludec u_aludec (
    .op5        (op[5]),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .aluop      (aluop_s),
    .alucontrol (alucontrol)
  );

  // State already sits in FETCH during reset; enables are held off until release
  assign pcwrite   = reset_n & (pcupdate_s | (branch_s & zero));
  assign irwrite   = reset_n & irwrite_s;
  assign regwrite  = reset_n & regwrite_s;
  assign memwrite  = reset_n & memwrite_s;
  assign illegal   = reset_n & illegal_s;
  assign adrsrc    = adrsrc_s;
  assign resultsrc = resultsrc_s;
  assign alusrca   = alusrca_s;
  assign alusrcb   = alusrcb_s;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: each instruction pushes its expected
// per-cycle output vectors, which are popped and compared every cycle.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
  logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
  logic [2:0] alucontrol;

  int n_vec = 0;
  int n_err = 0;
  logic [16:0] sb_q[$];
  string       tag_q[$];

  localparam int ST_F = 0, ST_D = 1, ST_MA = 2, ST_MR = 3, ST_MWB = 4, ST_MW = 5;
  localparam int ST_ER = 6, ST_EI = 7, ST_AWB = 8, ST_BEQ = 9, ST_JAL = 10, ST_RST = 11;

  mc_controller dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .pcwrite(pcwrite), .adrsrc(adrsrc), .memwrite(memwrite),
    .irwrite(irwrite), .regwrite(regwrite), .resultsrc(resultsrc), .alusrca(alusrca),
    .alusrcb(alusrcb), .immsrc(immsrc), .alucontrol(alucontrol), .illegal(illegal)
  );

  always #5 clk = ~clk;

  wire [16:0] obs = {pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc,
                     alusrca, alusrcb, immsrc, alucontrol, illegal};

  task automatic check_vec(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_imm(input logic [6:0] o);
    case (o)
      7'b0100011: return 2'b01;
      7'b1100011: return 2'b10;
      7'b1101111: return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  function automatic logic [2:0] exp_funct_alu(input logic [6:0] o, input logic [2:0] f3,
                                                input logic f7);
    case (f3)
      3'b000:  return (f7 && o == 7'b0110011) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b100:  return 3'b100;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [16:0] exp_vec(input int st, input logic [6:0] o,
                                          input logic [2:0] f3, input logic f7, input logic z);
    logic pcw, adr, mw, ir, rw, ill;
    logic [1:0] rs, a, b;
    logic [2:0] alu;
    pcw = 1'b0; adr = 1'b0; mw = 1'b0; ir = 1'b0; rw = 1'b0; ill = 1'b0;
    rs = 2'b00; a = 2'b00; b = 2'b00; alu = 3'b000;
    case (st)
      ST_RST: begin rs = 2'b10; b = 2'b10; end
      ST_F:   begin pcw = 1'b1; ir = 1'b1; rs = 2'b10; b = 2'b10; end
      ST_D: begin
        a = 2'b01; b = 2'b01;
        ill = !(o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                          7'b1100011, 7'b1101111});
      end
      ST_MA:  begin a = 2'b10; b = 2'b01; end
      ST_MR:  adr = 1'b1;
      ST_MWB: begin rs = 2'b01; rw = 1'b1; end
      ST_MW:  begin adr = 1'b1; mw = 1'b1; end
      ST_ER:  begin a = 2'b10; alu = exp_funct_alu(o, f3, f7); end
      ST_EI:  begin a = 2'b10; b = 2'b01; alu = exp_funct_alu(o, f3, f7); end
      ST_AWB: rw = 1'b1;
      ST_BEQ: begin a = 2'b10; alu = 3'b001; pcw = z; end
      ST_JAL: begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
      default: ;
    endcase
    return {pcw, adr, mw, ir, rw, rs, a, b, exp_imm(o), alu, ill};
  endfunction

  task automatic push_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                            input logic f7, input logic z);
    int seq[$];
    case (o)
      7'b0000011: seq = '{ST_F, ST_D, ST_MA, ST_MR, ST_MWB};
      7'b0100011: seq = '{ST_F, ST_D, ST_MA, ST_MW};
      7'b0110011: seq = '{ST_F, ST_D, ST_ER, ST_AWB};
      7'b0010011: seq = '{ST_F, ST_D, ST_EI, ST_AWB};
      7'b1101111: seq = '{ST_F, ST_D, ST_JAL, ST_AWB};
      7'b1100011: seq = '{ST_F, ST_D, ST_BEQ};
      default:    seq = '{ST_F, ST_D};
    endcase
    foreach (seq[i]) begin
      sb_q.push_back(exp_vec(seq[i], o, f3, f7, z));
      tag_q.push_back($sformatf("%s_c%0d", name, i + 1));
    end
  endtask

  task automatic push_reset(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      sb_q.push_back(exp_vec(ST_RST, op, funct3, funct7b5, zero));
      tag_q.push_back($sformatf("%s_%0d", name, i));
    end
  endtask

  // sample on the falling edge, then step to just after the next rising edge
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        check_vec("sb_empty", obs, ~obs);
      end else begin
        check_vec(tag_q.pop_front(), obs, sb_q.pop_front());
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply(input string name, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic z);
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    push_instr(name, o, f3, f7, z);
    run(sb_q.size());
  endtask

  initial begin
    reset_n = 1'b0; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; zero = 1'b0;
    push_reset("reset", 3);
    run(3);
    reset_n = 1'b1;

    apply("sub",    7'b0110011, 3'b000, 1'b1, 1'b0);
    apply("addi_f7", 7'b0010011, 3'b000, 1'b1, 1'b0);
    apply("slti",   7'b0010011, 3'b010, 1'b0, 1'b0);
    apply("andi",   7'b0010011, 3'b111, 1'b0, 1'b0);
    apply("xor",    7'b0110011, 3'b100, 1'b0, 1'b0);
    apply("or",     7'b0110011, 3'b110, 1'b1, 1'b0);
    apply("beq_z1", 7'b1100011, 3'b000, 1'b0, 1'b1);
    apply("beq_z0", 7'b1100011, 3'b000, 1'b0, 1'b0);
    apply("lw",     7'b0000011, 3'b010, 1'b0, 1'b0);
    apply("sw",     7'b0100011, 3'b010, 1'b0, 1'b1);
    apply("jal",    7'b1101111, 3'b000, 1'b0, 1'b1);
    apply("illegal", 7'b0000000, 3'b000, 1'b0, 1'b0);

    // reset asserted during MEMREAD of a load
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    push_instr("lw_rst", op, funct3, funct7b5, zero);
    run(3);
    @(negedge clk);
    check_vec(tag_q.pop_front(), obs, sb_q.pop_front());
    #1 reset_n = 1'b0;
    sb_q.delete();
    tag_q.delete();
    #1 check_vec("rst_mid", obs, exp_vec(ST_RST, op, funct3, funct7b5, zero));
    push_reset("rst_hold", 2);
    run(2);
    reset_n = 1'b1;
    apply("add_after_rst", 7'b0110011, 3'b000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the RISC-V datapath. It holds the main instruction-sequencing state machine and drives every datapath select and enable, including the 3-bit `alucontrol` code that the ALU consumes. Each instruction takes 3–5 cycles, and exactly one datapath phase runs per cycle. The block sits between the instruction register (it reads the `op`/`funct` fields and `zero`) and the shared multicycle datapath (it drives the muxes, write enables and ALU operation).

## Interface
Parameters: none.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `op` in 7: instruction opcode field.
- `funct3` in 3: instruction funct3 field.
- `funct7b5` in 1: instruction bit 30.
- `zero` in 1: ALU result-is-zero flag.
- `pcwrite` out 1: PC register enable.
- `adrsrc` out 1: memory address select; 0 = PC, 1 = ALU result register.
- `memwrite` out 1: data memory write enable.
- `irwrite` out 1: instruction register / oldPC enable.
- `regwrite` out 1: register file write enable.
- `resultsrc` out 2: result select; 00 = ALUOut, 01 = data, 10 = ALU result.
- `alusrca` out 2: ALU operand A select; 00 = PC, 01 = oldPC, 10 = rs1.
- `alusrcb` out 2: ALU operand B select; 00 = rs2, 01 = imm, 10 = constant 4.
- `immsrc` out 2: immediate format; 00 = I, 01 = S, 10 = B, 11 = J.
- `alucontrol` out 3: ALU operation; 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
- `illegal` out 1: one-cycle pulse when an unsupported opcode is decoded.

## Operation
Opcodes:
- lw 0000011
- sw 0100011
- R-type 0110011
- I-ALU 0010011
- beq 1100011
- jal 1101111

State machine states and transitions:
- FETCH → DECODE.
- DECODE:
  - lw or sw → MEMADR.
  - R-type → EXECUTER.
  - I-ALU → EXECUTEI.
  - jal → JAL.
  - beq → BEQ.
  - any other opcode → FETCH, with `illegal`=1 during DECODE.
- MEMADR: lw → MEMREAD; sw → MEMWRITE.
- MEMREAD → MEMWB → FETCH.
- MEMWRITE → FETCH.
- EXECUTER and EXECUTEI → ALUWB → FETCH.
- JAL → ALUWB.
- BEQ → FETCH.

Moore outputs per state. Any signal not listed is 0, and aluop is 00.
- FETCH: irwrite=1, pcupdate=1, alusrcb=10, resultsrc=10.
- DECODE: alusrca=01, alusrcb=01.
- MEMADR: alusrca=10, alusrcb=01.
- MEMREAD: adrsrc=1.
- MEMWB: resultsrc=01, regwrite=1.
- MEMWRITE: adrsrc=1, memwrite=1.
- EXECUTER: alusrca=10, aluop=10.
- EXECUTEI: alusrca=10, alusrcb=01, aluop=10.
- ALUWB: regwrite=1.
- BEQ: alusrca=10, aluop=01, branch=1.
- JAL: alusrca=01, alusrcb=10, pcupdate=1.

Combinational outputs:
- `pcwrite` = pcupdate | (branch & zero).
- `immsrc` is decoded from `op` alone, in every state. Unknown opcodes give 00.

ALU decode (internal 2-bit aluop):
- aluop 00 → add; aluop 01 → sub.
- aluop 10 → decode funct3:
  - 000: sub when funct7b5 & op[5], otherwise add. `addi` never subtracts.
  - 010: slt.
  - 100: xor.
  - 110: or.
  - 111: and.
  - any other funct3: add.
- `alucontrol` is never X.

## Timing
- Reset (`reset_n`=0, asynchronous):
  - State goes to FETCH immediately.
  - `pcwrite`, `irwrite`, `regwrite`, `memwrite` and `illegal` are forced to 0 while reset is held.
  - All other outputs take their FETCH values: adrsrc 0, resultsrc 10, alusrca 00, alusrcb 10, alucontrol 000.
- First FETCH with enables active is the first rising edge after `reset_n` rises.
- Latency in cycles, FETCH inclusive:
  - beq: 3.
  - sw, R-type, I-ALU, jal: 4.
  - lw: 5.
  - illegal opcode: 2.
- Reset asserted mid-instruction abandons it: no further regwrite or memwrite, and the block resumes at FETCH.
- `op`, `funct3` and `funct7b5` must be stable from DECODE until the return to FETCH; the instruction register guarantees this.
- `zero` is sampled only in BEQ.

## Structure
- Package `riscv_pkg` holds:
  - the state enum `statetype`;
  - opcode localparams;
  - `alucontrol` encodings;
  - aluop, resultsrc, alusrca and alusrcb encodings.
- Sub-module `aludec` (combinational): inputs op[5], funct3, funct7b5, aluop; output alucontrol.
- Top level contains the state register, next-state logic, output decode and the immsrc decoder.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles → irwrite=0, pcwrite=0, alucontrol=000, resultsrc=10. Release → the next cycle is FETCH with irwrite=1, pcwrite=1.
- R-type sub (op=0110011, funct3=000, funct7b5=1) → sequence FETCH, DECODE, EXECUTER, ALUWB; alucontrol=001 in EXECUTER; regwrite=1 only in cycle 4.
- addi with funct7b5=1 (op=0010011, funct3=000) → alucontrol=000 in EXECUTEI. Also check funct3=010 → 101, funct3=111 → 010.
- beq with zero=1, then zero=0 → BEQ has alucontrol=001; pcwrite=1 versus 0; 3 cycles per instruction.
- lw then sw → lw: MEMREAD adrsrc=1, MEMWB resultsrc=01 regwrite=1, 5 cycles. sw: memwrite=1 only in MEMWRITE, 4 cycles. immsrc is 00 for lw and 01 for sw.
- Illegal op=0000000 → one `illegal` pulse in DECODE and return to FETCH; no regwrite or memwrite. Also assert reset during MEMREAD → memwrite and regwrite stay 0 and the block restarts at FETCH.
